ram_port_arbiter: RTL

Sequences the single ram512x8 port (MFA/MFC handshake) and shares it between two requesters: the instruction-fetch side and the load/store side of the control unit. It latches the address, data and size of one winning request, holds MFA until MFC returns, captures read data and returns a one-cycle ack. Round-robin arbitration, alignment checking and an MFC timeout are included. It sits between the controlUnit/MAR/MDR and the RAM, replacing direct CU drive of MFA/RW/dataSize.

---
 rtl/ram_port_arbiter_pkg.sv | 30 +++
 rtl/ram_port_arbiter_rr_arbiter2.sv | 36 +++
 rtl/ram_port_arbiter.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/ram_port_arbiter_pkg.sv
// Shared encodings for the RAM port arbiter: FSM states, access sizes,
// requester IDs and the alignment rule applied at grant time.
package ram_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    localparam logic GRANT_IF = 1'b0;
    localparam logic GRANT_LS = 1'b1;

    // Words must sit on a 4-byte boundary, halfwords on a 2-byte boundary.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lsb);
        logic bad;
        bad = 1'b0;
        case (size)
            SIZE_WORD: bad = (addr_lsb != 2'b00);
            SIZE_HALF: bad = addr_lsb[0];
            default:   bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/ram_port_arbiter_rr_arbiter2.sv
// Two-requester round-robin arbiter: combinational grant, registered
// memory of which side won the last contested grant.
module rr_arbiter2 (
    input  logic Clk,
    input  logic reset,
    input  logic req_if,
    input  logic req_ls,
    input  logic take,
    output logic gnt_valid,
    output logic gnt_id
);
    import ram_port_arbiter_pkg::*;

    logic last_grant_reg;

    // A lone requester always wins; on a tie the side not served last wins.
    always_comb begin
        gnt_valid = req_if | req_ls;
        gnt_id    = GRANT_IF;
        if (req_if && req_ls) begin
            gnt_id = ~last_grant_reg;
        end else if (req_ls) begin
            gnt_id = GRANT_LS;
        end
    end

    // Only contested grants move the pointer, so fetch wins the first tie.
    always_ff @(posedge Clk) begin
        if (reset) begin
            last_grant_reg <= GRANT_LS;
        end else if (take && req_if && req_ls) begin
            last_grant_reg <= gnt_id;
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares the single MFA/MFC RAM port between instruction fetch and
// load/store: latches one winning request, holds MFA until MFC or timeout,
// captures read data and returns a one-cycle ack (with error qualifier).
module ram_port_arbiter #(
    parameter int ADDR_W  = 9,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              Clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic              if_err,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              ls_req,
    input  logic              ls_rw,
    input  logic [1:0]        ls_size,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic              ls_ack,
    output logic              ls_err,
    output logic [DATA_W-1:0] ls_rdata,
    output logic              ram_mfa,
    output logic              ram_rw,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic [1:0]        ram_size,
    input  logic              ram_mfc,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              busy
);
    import ram_port_arbiter_pkg::*;

    localparam int              CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t            state_reg, state_next;
    logic              grant_reg;
    logic              rw_reg;
    logic              err_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [1:0]        size_reg;
    logic [DATA_W-1:0] wdata_reg;
    logic [CNT_W-1:0]  cnt_reg;

    logic              in_idle;
    logic              gnt_valid;
    logic              gnt_id;
    logic [ADDR_W-1:0] sel_addr;
    logic              sel_rw;
    logic [1:0]        sel_size;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_misaligned;
    logic              timed_out;
    logic [1:0]        ack_vec;
    logic [1:0]        err_vec;

    assign in_idle   = (state_reg == IDLE);
    assign timed_out = (cnt_reg == CNT_LAST);

    rr_arbiter2 u_arb (
        .Clk       (Clk),
        .reset     (reset),
        .req_if    (if_req),
        .req_ls    (ls_req),
        .take      (in_idle),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id)
    );

    // Mux the winning request's fields; fetch is always a word read.
    always_comb begin
        sel_addr  = if_addr;
        sel_rw    = 1'b1;
        sel_size  = SIZE_WORD;
        sel_wdata = '0;
        if (gnt_id == GRANT_LS) begin
            sel_addr  = ls_addr;
            sel_rw    = ls_rw;
            sel_size  = ls_size;
            sel_wdata = ls_wdata;
        end
        sel_misaligned = misaligned(sel_size, sel_addr[1:0]);
    end

    // Next-state: misaligned grants skip the RAM; MFC beats timeout.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (gnt_valid) begin
                    state_next = sel_misaligned ? DONE : ACCESS;
                end
            end
            ACCESS: begin
                if (ram_mfc || timed_out) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register; reset from any state aborts without an ack.
    always_ff @(posedge Clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Latch the granted request and track the access duration / outcome.
    always_ff @(posedge Clk) begin
        if (reset) begin
            grant_reg <= GRANT_IF;
            rw_reg    <= 1'b0;
            err_reg   <= 1'b0;
            addr_reg  <= '0;
            size_reg  <= SIZE_BYTE;
            wdata_reg <= '0;
            cnt_reg   <= '0;
        end else if (in_idle && gnt_valid) begin
            grant_reg <= gnt_id;
            rw_reg    <= sel_rw;
            addr_reg  <= sel_addr;
            size_reg  <= sel_size;
            wdata_reg <= sel_wdata;
            err_reg   <= sel_misaligned;
            cnt_reg   <= '0;
        end else if (state_reg == ACCESS) begin
            cnt_reg <= cnt_reg + 1'b1;
            if (!ram_mfc && timed_out) begin
                err_reg <= 1'b1;
            end
        end
    end

    // Per-requester read-data holding register and ack/err decode.
    genvar gi;
    for (gi = 0; gi < 2; gi++) begin : g_req
        logic [DATA_W-1:0] rdata_reg;

        // Capture only on a completed read owned by this requester.
        always_ff @(posedge Clk) begin
            if (reset) begin
                rdata_reg <= '0;
            end else if (state_reg == ACCESS && ram_mfc && rw_reg && grant_reg == 1'(gi)) begin
                rdata_reg <= ram_rdata;
            end
        end

        assign ack_vec[gi] = (state_reg == DONE) && (grant_reg == 1'(gi));
        assign err_vec[gi] = ack_vec[gi] && err_reg;
    end

    assign if_ack    = ack_vec[0];
    assign if_err    = err_vec[0];
    assign if_rdata  = g_req[0].rdata_reg;
    assign ls_ack    = ack_vec[1];
    assign ls_err    = err_vec[1];
    assign ls_rdata  = g_req[1].rdata_reg;

    assign ram_mfa   = (state_reg == ACCESS);
    assign ram_rw    = rw_reg;
    assign ram_addr  = addr_reg;
    assign ram_wdata = wdata_reg;
    assign ram_size  = size_reg;
    assign busy      = !in_idle;

endmodule
